// File: rtl/wb_test_status_pkg.sv
// Shared definitions for the Wishbone test-status port.
// Holds register byte offsets, CTRL bit indices, the watchdog failure code,
// and a byte-select merge helper used by every writable register.
package wb_test_status_pkg;

  localparam logic [3:0] REG_STATUS   = 4'h0;
  localparam logic [3:0] REG_CTRL     = 4'h4;
  localparam logic [3:0] REG_WDT_LOAD = 4'h8;
  localparam logic [3:0] REG_HIST     = 4'hC;

  localparam int CTRL_OE_EN   = 0;
  localparam int CTRL_WDT_EN  = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_WDT_CLR = 3;

  localparam logic [15:0] FAIL_CODE = 16'hDEAD;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/wb_test_status_hist.sv
// Circular history FIFO of status codes with overwrite-on-full.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   push_i, data_i  append a code; when full the oldest entry is dropped
//   pop_i           remove the oldest entry (ignored when empty)
//   data_o          oldest entry (meaningless while count_o == 0)
//   count_o         number of valid entries, 0..DEPTH
module wb_test_status_hist #(
  parameter  int CODE_W = 16,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CODE_W-1:0] data_i,
  output logic [CODE_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              full, pop_ok, drop;

  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok = pop_i & (cnt_q != '0);
  // A push into a full FIFO retires the oldest entry to make room.
  assign drop   = push_i & full & ~pop_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i)         wr_q <= wr_q + 1'b1;
      if (pop_ok || drop) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_ok && !full) cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_i)     cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_test_status.sv
// Wishbone test-status slave: firmware writes progress codes that are driven
// to the pads, a history FIFO records them, and a watchdog forces FAIL_CODE
// when firmware stops reporting.
// Ports:
//   mclk, reset_n            clock, async active-low reset
//   wbs_*                    Wishbone slave (single-cycle registered ack)
//   status_o, status_oen_n   pad value and active-low output enable
//   wdt_expired_o            sticky watchdog expiry flag
//   irq_o                    wdt_expired_o gated by CTRL.irq_en
module wb_test_status
  import wb_test_status_pkg::*;
#(
  parameter int CODE_W     = 16,
  parameter int HIST_DEPTH = 4,
  parameter int WDT_W      = 24
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [CODE_W-1:0] status_o,
  output logic [CODE_W-1:0] status_oen_n,
  output logic              wdt_expired_o,
  output logic              irq_o
);

  localparam int CNT_W = $clog2(HIST_DEPTH + 1);

  logic              ack_q;
  logic [31:0]       dat_q, dat_d;
  logic [CODE_W-1:0] status_q, status_d;
  logic              oe_en_q, oe_en_d;
  logic              wdt_en_q, wdt_en_d;
  logic              irq_en_q, irq_en_d;
  logic [WDT_W-1:0]  load_q, load_d;
  logic [WDT_W-1:0]  cnt_q, cnt_d;
  logic              exp_q, exp_d;

  logic              accept, wr, rd;
  logic [3:0]        adr;
  logic              st_wr, ctrl_wr, load_wr, hist_rd;
  logic [31:0]       st_m32, ctrl_m32, load_m32, rdata;
  logic              clr, kick;
  logic [CODE_W-1:0] hist_dout;
  logic [CNT_W-1:0]  hist_cnt;

  // Holding off on ack_q makes each access exactly two cycles.
  assign accept = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr     = accept & wbs_we_i;
  assign rd     = accept & ~wbs_we_i;
  assign adr    = {wbs_adr_i[3:2], 2'b00};

  assign st_wr   = wr & (adr == REG_STATUS);
  assign ctrl_wr = wr & (adr == REG_CTRL);
  assign load_wr = wr & (adr == REG_WDT_LOAD);
  assign hist_rd = rd & (adr == REG_HIST);

  assign st_m32   = merge_bytes(32'(status_q), wbs_dat_i, wbs_sel_i);
  assign ctrl_m32 = merge_bytes({29'd0, irq_en_q, wdt_en_q, oe_en_q}, wbs_dat_i, wbs_sel_i);
  assign load_m32 = merge_bytes(32'(load_q), wbs_dat_i, wbs_sel_i);

  wb_test_status_hist #(
    .CODE_W (CODE_W),
    .DEPTH  (HIST_DEPTH)
  ) u_hist (
    .clk_i   (mclk),
    .rst_ni  (reset_n),
    .push_i  (st_wr),
    .pop_i   (hist_rd),
    .data_i  (st_m32[CODE_W-1:0]),
    .data_o  (hist_dout),
    .count_o (hist_cnt)
  );

  // Register file next-state.
  always_comb begin
    status_d = st_wr   ? st_m32[CODE_W-1:0]      : status_q;
    oe_en_d  = ctrl_wr ? ctrl_m32[CTRL_OE_EN]    : oe_en_q;
    wdt_en_d = ctrl_wr ? ctrl_m32[CTRL_WDT_EN]   : wdt_en_q;
    irq_en_d = ctrl_wr ? ctrl_m32[CTRL_IRQ_EN]   : irq_en_q;
    load_d   = load_wr ? load_m32[WDT_W-1:0]     : load_q;
  end

  // Watchdog: any reload source beats a same-cycle expiry.
  assign clr  = ctrl_wr & ctrl_m32[CTRL_WDT_CLR];
  assign kick = (st_wr & wdt_en_q) | clr | (ctrl_wr & ~wdt_en_q & wdt_en_d);

  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (clr) exp_d = 1'b0;
    if (kick) begin
      cnt_d = load_q;
    end else if (wdt_en_q && !exp_q) begin
      // Counter at 1 (or a zero load) reaches 0 on this edge.
      if (cnt_q <= WDT_W'(1)) begin
        cnt_d = '0;
        exp_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Read mux; HIST count field sits at [19:16].
  always_comb begin
    rdata = '0;
    unique case (adr)
      REG_STATUS:   rdata = 32'(status_q);
      REG_CTRL:     rdata = {29'd0, irq_en_q, wdt_en_q, oe_en_q};
      REG_WDT_LOAD: rdata = 32'(load_q);
      REG_HIST: begin
        if (hist_cnt != '0) begin
          rdata[31]           = 1'b1;
          rdata[19:16]        = 4'(hist_cnt);
          rdata[CODE_W-1:0]   = hist_dout;
        end
      end
      default:      rdata = '0;
    endcase
    dat_d = rd ? rdata : 32'd0;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      status_q <= '0;
      oe_en_q  <= 1'b0;
      wdt_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      load_q   <= '1;
      cnt_q    <= '0;
      exp_q    <= 1'b0;
    end else begin
      ack_q    <= accept;
      dat_q    <= dat_d;
      status_q <= status_d;
      oe_en_q  <= oe_en_d;
      wdt_en_q <= wdt_en_d;
      irq_en_q <= irq_en_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign status_o      = exp_q ? CODE_W'(FAIL_CODE) : status_q;
  assign status_oen_n  = {CODE_W{~oe_en_q}};
  assign wdt_expired_o = exp_q;
  assign irq_o         = exp_q & irq_en_q;

  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[1:0], st_m32, ctrl_m32, load_m32};

endmodule
